// File: rtl/shm_dma_requester.sv
// Processor-side requester for the shared-memory DMA. Core commands go into a 2-entry FIFO
// and are issued one at a time over the toggle trigger/ack handshake. A status is returned for each.
module shm_dma_requester #(
  parameter int SIZE      = 4,
  parameter int PROCSIZE  = 4,
  parameter int PAGE_SIZE = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clock,
  input  logic                      start,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_action,
  input  logic [SIZE-1:0]           cmd_ptr,
  input  logic [PROCSIZE-1:0]       cmd_copy_start,
  input  logic [PROCSIZE-1:0]       cmd_copy_length,
  output logic                      trigger,
  output logic [1:0]                action,
  output logic [SIZE-1:0]           ptr,
  output logic [PROCSIZE-1:0]       copy_start,
  output logic [PROCSIZE-1:0]       copy_length,
  input  logic                      ack,
  input  logic [SIZE-PAGE_SIZE-1:0] ptr_in,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [1:0]                resp_status,
  output logic [SIZE-PAGE_SIZE-1:0] resp_page,
  output logic                      busy
);

  localparam logic [1:0] ACT_FREE    = 2'd2;
  localparam logic [1:0] ACT_ILLEGAL = 2'd3;
  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_BAD_ARG  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;
  localparam logic [PROCSIZE:0] LOCAL_WORDS = {1'b1, {PROCSIZE{1'b0}}};
  localparam logic [7:0] TIMEOUT_CYCLES = 8'(TIMEOUT);

  typedef struct packed {
    logic [1:0]          action;
    logic [SIZE-1:0]     ptr;
    logic [PROCSIZE-1:0] copyStart;
    logic [PROCSIZE-1:0] copyLength;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  cmd_t                      fifoMem_q [2];
  logic                      wrPtr_q, wrPtr_d;
  logic                      rdPtr_q, rdPtr_d;
  logic [1:0]                count_q, count_d;
  logic                      push, pop;
  cmd_t                      head;
  logic [PROCSIZE:0]         endAddr;
  logic                      badArg;

  state_t                    state_q;
  cmd_t                      cur_q;
  logic                      trigger_q;
  logic [1:0]                action_q;
  logic [SIZE-1:0]           ptr_q;
  logic [PROCSIZE-1:0]       copyStart_q;
  logic [PROCSIZE-1:0]       copyLength_q;
  logic                      lastAck_q;
  logic                      stale_q;
  logic [7:0]                timer_q;
  logic                      respValid_q;
  logic [1:0]                respStatus_q;
  logic [SIZE-PAGE_SIZE-1:0] respPage_q;

  assign cmd_ready = (count_q != 2'd2);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != 2'd0) && !respValid_q;
  assign head      = fifoMem_q[rdPtr_q];

  // The end address needs one extra bit so a window ending exactly at the top of local memory is legal
  assign endAddr = {1'b0, head.copyStart} + {1'b0, head.copyLength};
  assign badArg  = (head.action == ACT_ILLEGAL)
                || ((head.action != ACT_FREE) && (head.copyLength == '0))
                || (endAddr > LOCAL_WORDS);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = ~wrPtr_q;
    if (pop)  rdPtr_d = ~rdPtr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (start) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifoMem_q[wrPtr_q] <= {cmd_action, cmd_ptr, cmd_copy_start, cmd_copy_length};
  end

  always_ff @(posedge clock) begin
    if (start) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      trigger_q    <= 1'b0;
      action_q     <= '0;
      ptr_q        <= '0;
      copyStart_q  <= '0;
      copyLength_q <= '0;
      lastAck_q    <= ack;
      stale_q      <= 1'b0;
      timer_q      <= '0;
      respValid_q  <= 1'b0;
      respStatus_q <= ST_OK;
      respPage_q   <= '0;
    end else begin
      // Outside WAIT any ack edge belongs to an abandoned or timed-out command and is swallowed
      if ((state_q != S_WAIT) && (ack != lastAck_q)) begin
        lastAck_q <= ack;
        stale_q   <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_q <= head;
            if (badArg) begin
              respStatus_q <= ST_BAD_ARG;
              respValid_q  <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          action_q     <= cur_q.action;
          ptr_q        <= cur_q.ptr;
          copyStart_q  <= cur_q.copyStart;
          copyLength_q <= cur_q.copyLength;
          trigger_q    <= ~trigger_q;
          timer_q      <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (ack != lastAck_q) begin
            lastAck_q <= ack;
            if (stale_q) begin
              stale_q <= 1'b0;
            end else begin
              respPage_q   <= ptr_in;
              respStatus_q <= ST_OK;
              respValid_q  <= 1'b1;
              state_q      <= S_RESP;
            end
          end else if (timer_q == TIMEOUT_CYCLES) begin
            respStatus_q <= ST_TIMEOUT;
            stale_q      <= 1'b1;
            respValid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            respValid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trigger     = trigger_q;
  assign action      = action_q;
  assign ptr         = ptr_q;
  assign copy_start  = copyStart_q;
  assign copy_length = copyLength_q;
  assign resp_valid  = respValid_q;
  assign resp_status = respStatus_q;
  assign resp_page   = respPage_q;
  assign busy        = (count_q != 2'd0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_shm_dma_requester.sv
// Self-checking bench for shm_dma_requester: a behavioural DMA answers each trigger toggle,
// and expected triggers and responses are queued on push and checked when the DUT produces them.
module tb_shm_dma_requester;

  localparam int SIZE      = 4;
  localparam int PROCSIZE  = 4;
  localparam int PAGE_SIZE = 2;
  localparam int TIMEOUT   = 255;
  localparam int PW        = SIZE - PAGE_SIZE;

  logic                clock = 1'b0;
  logic                start = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_action = '0;
  logic [SIZE-1:0]     cmd_ptr = '0;
  logic [PROCSIZE-1:0] cmd_copy_start = '0;
  logic [PROCSIZE-1:0] cmd_copy_length = '0;
  logic                trigger;
  logic [1:0]          action;
  logic [SIZE-1:0]     ptr;
  logic [PROCSIZE-1:0] copy_start;
  logic [PROCSIZE-1:0] copy_length;
  logic                ack = 1'b0;
  logic [PW-1:0]       ptr_in = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b1;
  logic [1:0]          resp_status;
  logic [PW-1:0]       resp_page;
  logic                busy;

  always #5 clock = ~clock;

  shm_dma_requester #(
    .SIZE(SIZE), .PROCSIZE(PROCSIZE), .PAGE_SIZE(PAGE_SIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_action(cmd_action), .cmd_ptr(cmd_ptr),
    .cmd_copy_start(cmd_copy_start), .cmd_copy_length(cmd_copy_length),
    .trigger(trigger), .action(action), .ptr(ptr), .copy_start(copy_start), .copy_length(copy_length),
    .ack(ack), .ptr_in(ptr_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status), .resp_page(resp_page),
    .busy(busy)
  );

  typedef struct {
    string      name;
    logic [1:0] act;
    logic [3:0] ptr;
    logic [3:0] cs;
    logic [3:0] cl;
    int         delay;
    int         expStatus;
  } cmdVec_t;

  typedef struct {
    string name;
    int    status;
    int    page;
    int    lat;
  } respExp_t;

  typedef struct {
    string name;
    int    act;
    int    ptr;
    int    cs;
    int    cl;
  } trigExp_t;

  respExp_t      respQ[$];
  trigExp_t      trigQ[$];
  respExp_t      rExp;
  trigExp_t      tExp;
  int            tests = 0;
  int            errors = 0;
  int            cyc = 0;
  int            trigCyc = 0;
  int            dmaDelay = 0;
  int            staleDelay = 0;
  logic [PW-1:0] stalePage = '0;
  bit            checkStable = 1'b1;
  logic          lastTrig = 1'b0;
  bit            pending = 1'b0;
  int            ackCnt = 0;
  int            staleCnt = 0;
  int            lastOut = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    tests++;
    errors++;
    $display("[TB] FAIL %s: event occurred, none was required", name);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // DMA model: answers each trigger toggle after dmaDelay cycles (0 = never) with page = ptr page + 2
  always @(negedge clock) begin
    if (start) begin
      lastTrig = trigger;
    end else if (trigger !== lastTrig) begin
      lastTrig = trigger;
      trigCyc  = cyc;
      pending  = (dmaDelay > 0);
      ackCnt   = dmaDelay;
      staleCnt = staleDelay;
      lastOut  = int'({action, ptr, copy_start, copy_length});
      if (trigQ.size() == 0) begin
        reportFail("unexpected trigger toggle");
      end else begin
        tExp = trigQ.pop_front();
        checkOutput({tExp.name, " action"}, int'(action), tExp.act);
        checkOutput({tExp.name, " ptr"}, int'(ptr), tExp.ptr);
        checkOutput({tExp.name, " copy_start"}, int'(copy_start), tExp.cs);
        checkOutput({tExp.name, " copy_length"}, int'(copy_length), tExp.cl);
      end
    end else begin
      if (pending) begin
        if (checkStable) checkOutput("outputs stable in WAIT", int'({action, ptr, copy_start, copy_length}), lastOut);
        ackCnt--;
        if (ackCnt == 0) begin
          ack     = ~ack;
          ptr_in  = ptr[SIZE-1:PAGE_SIZE] + PW'(2);
          pending = 1'b0;
        end
      end
      if (staleCnt > 0) begin
        staleCnt--;
        if (staleCnt == 0) begin
          ack    = ~ack;
          ptr_in = stalePage;
        end
      end
    end
  end

  // Response scoreboard: pops one expectation per completed handshake
  always @(negedge clock) begin
    if ((resp_valid === 1'b1) && resp_ready) begin
      if (respQ.size() == 0) begin
        reportFail("unexpected response");
      end else begin
        rExp = respQ.pop_front();
        checkOutput({rExp.name, " status"}, int'(resp_status), rExp.status);
        if (rExp.status == 0) checkOutput({rExp.name, " page"}, int'(resp_page), rExp.page);
        if (rExp.lat >= 0) checkOutput({rExp.name, " latency"}, cyc - trigCyc, rExp.lat);
      end
    end
  end

  task automatic applyStimulus(input cmdVec_t v, input int lat, input bit expectResp);
    logic [1:0] pg;
    pg              = v.ptr[3:2] + 2'd2;
    cmd_valid       = 1'b1;
    cmd_action      = v.act;
    cmd_ptr         = v.ptr;
    cmd_copy_start  = v.cs;
    cmd_copy_length = v.cl;
    if (v.expStatus != 1) trigQ.push_back('{v.name, int'(v.act), int'(v.ptr), int'(v.cs), int'(v.cl)});
    if (expectResp) respQ.push_back('{v.name, v.expStatus, int'(pg), lat});
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitResponses(input string tag, input int budget);
    int n;
    n = 0;
    while ((respQ.size() != 0) && (n < budget)) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput({tag, " responses drained"}, respQ.size(), 0);
    respQ.delete();
  endtask

  task automatic runCmd(input cmdVec_t v);
    dmaDelay = v.delay;
    checkOutput({v.name, " cmd_ready"}, int'(cmd_ready), 1);
    applyStimulus(v, (v.expStatus == 0) ? v.delay + 1 : -1, 1'b1);
    waitResponses(v.name, 400);
    @(posedge clock);
    #1;
    checkOutput({v.name, " busy after"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmdVec_t vecs[9];
    cmdVec_t v;
    vecs[0] = '{"write_basic",   2'd1, 4'd0,  4'd2,  4'd3,  10, 0};
    vecs[1] = '{"read_overflow", 2'd0, 4'd5,  4'd14, 4'd3,  1,  1};
    vecs[2] = '{"illegal_act",   2'd3, 4'd0,  4'd0,  4'd1,  1,  1};
    vecs[3] = '{"read_len0",     2'd0, 4'd4,  4'd1,  4'd0,  1,  1};
    vecs[4] = '{"write_sum16",   2'd1, 4'd12, 4'd12, 4'd4,  2,  0};
    vecs[5] = '{"free_len0",     2'd2, 4'd8,  4'd0,  4'd0,  1,  0};
    vecs[6] = '{"read_sum17",    2'd0, 4'd6,  4'd15, 4'd2,  1,  1};
    vecs[7] = '{"read_top_word", 2'd0, 4'd7,  4'd15, 4'd1,  4,  0};
    vecs[8] = '{"write_len15",   2'd1, 4'd13, 4'd0,  4'd15, 1,  0};

    repeat (2) @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("reset cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset trigger", int'(trigger), 0);
    checkOutput("reset action", int'(action), 0);
    checkOutput("reset ptr", int'(ptr), 0);
    checkOutput("reset copy_start", int'(copy_start), 0);
    checkOutput("reset copy_length", int'(copy_length), 0);
    checkOutput("reset resp_valid", int'(resp_valid), 0);
    checkOutput("reset resp_status", int'(resp_status), 0);
    checkOutput("reset resp_page", int'(resp_page), 0);
    checkOutput("reset busy", int'(busy), 0);

    for (int i = 0; i < 9; i++) runCmd(vecs[i]);

    // Timeout, then a late ack arriving inside the next command's WAIT must be swallowed
    dmaDelay = 0;
    v = '{"free_timeout", 2'd2, 4'd8, 4'd0, 4'd0, 0, 2};
    applyStimulus(v, TIMEOUT + 1, 1'b1);
    waitResponses("free_timeout", 400);
    stalePage  = 2'd0;
    staleDelay = 1;
    dmaDelay   = 3;
    v = '{"read_after_timeout", 2'd0, 4'd4, 4'd0, 4'd1, 3, 0};
    applyStimulus(v, 4, 1'b1);
    waitResponses("read_after_timeout", 100);
    staleDelay = 0;
    @(posedge clock);
    #1;
    checkOutput("after stale busy", int'(busy), 0);

    // Back-to-back pushes with the response held off
    dmaDelay   = 2;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = '{$sformatf("b2b_%0d", i), 2'd1, 4'(i * 4), 4'd0, 4'd1, 2, 0};
      checkOutput({v.name, " cmd_ready"}, int'(cmd_ready), 1);
      applyStimulus(v, (i == 0) ? -1 : 3, 1'b1);
    end
    checkOutput("b2b cmd_ready full", int'(cmd_ready), 0);
    cmd_valid  = 1'b1;
    cmd_action = 2'd3;
    cmd_ptr    = '0;
    repeat (8) begin
      @(posedge clock);
      #1;
    end
    checkOutput("b2b resp_valid held", int'(resp_valid), 1);
    checkOutput("b2b resp_status held", int'(resp_status), 0);
    checkOutput("b2b cmd_ready held", int'(cmd_ready), 0);
    checkOutput("b2b busy held", int'(busy), 1);
    cmd_valid  = 1'b0;
    resp_ready = 1'b1;
    waitResponses("b2b", 200);

    // Reset while waiting for ack; the late ack must not produce a response
    checkStable = 1'b0;
    dmaDelay    = 20;
    v = '{"reset_victim", 2'd1, 4'd4, 4'd0, 4'd2, 20, 0};
    applyStimulus(v, -1, 1'b0);
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    checkOutput("victim trigger before reset", int'(trigger), 1);
    checkOutput("victim busy before reset", int'(busy), 1);
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("mid reset trigger", int'(trigger), 0);
    checkOutput("mid reset action", int'(action), 0);
    checkOutput("mid reset resp_valid", int'(resp_valid), 0);
    checkOutput("mid reset busy", int'(busy), 0);
    checkOutput("mid reset cmd_ready", int'(cmd_ready), 1);
    repeat (30) begin
      @(posedge clock);
      #1;
    end
    checkOutput("late ack resp_valid", int'(resp_valid), 0);
    checkStable = 1'b1;
    runCmd('{"after_reset", 2'd0, 4'd9, 4'd3, 4'd5, 5, 0});

    checkOutput("trigger queue drained", trigQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
